// File: rtl/apb_rd_seq_pkg.sv
// apb_rd_seq_pkg: state encoding and beat/count width helpers shared with the HRDATA assembly stage
package apb_rd_seq_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    function automatic int nbeats_f(int ahb_dw, int apb_dw);
        return ahb_dw / apb_dw;
    endfunction
    function automatic int cnt_w(int nbeats);
        return $clog2(nbeats) + 1;
    endfunction
endpackage

// File: rtl/apb_rd_seq.sv
// apb_rd_seq: splits one AHB read into 1..NBEATS APB reads, strobing each beat's PRDATA into its slice
module apb_rd_seq
    import apb_rd_seq_pkg::*;
#(
    parameter int AHB_DW = 32,
    parameter int APB_DW = 8,
    parameter int APB_AW = 32,
    localparam int NBEATS = nbeats_f(AHB_DW, APB_DW),
    localparam int CW = cnt_w(NBEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [APB_AW-1:0] i_addr,
    input  logic [CW-1:0]     i_beats,
    output logic              o_busy,
    output logic              o_psel,
    output logic              o_penable,
    output logic              o_pwrite,
    output logic [APB_AW-1:0] o_paddr,
    input  logic              i_pready,
    input  logic              i_pslverr,
    input  logic [APB_DW-1:0] i_prdata,
    output logic [NBEATS-1:0] o_load,
    output logic [APB_DW-1:0] o_data,
    output logic              o_done,
    output logic              o_err
);
    localparam int STEP = APB_DW / 8;
    state_t state;
    logic [CW-1:0] cnt, beats, cnt_nx;
    logic [APB_AW-1:0] base;
    logic beat_ok;
    assign cnt_nx = cnt + 1'b1;
    assign beat_ok = state == ACCESS && i_pready && !i_pslverr;
    // load and data bypass the registers so the slice captures on the completing edge
    assign o_load = NBEATS'(beat_ok) << cnt;
    assign o_data = i_prdata;
    assign o_pwrite = 1'b0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            beats     <= '0;
            base      <= '0;
            o_busy    <= 1'b0;
            o_psel    <= 1'b0;
            o_penable <= 1'b0;
            o_paddr   <= '0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    base    <= i_addr;
                    beats   <= (i_beats == '0) ? CW'(1) : i_beats;
                    cnt     <= '0;
                    o_paddr <= i_addr;
                    o_psel  <= 1'b1;
                    o_busy  <= 1'b1;
                    state   <= SETUP;
                end
                SETUP: begin
                    o_penable <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: if (i_pready) begin
                    o_penable <= 1'b0;
                    if (!i_pslverr) cnt <= cnt_nx;
                    if (i_pslverr || cnt_nx == beats) begin
                        o_psel <= 1'b0;
                        o_done <= 1'b1;
                        o_err  <= i_pslverr;
                        state  <= DONE;
                    end else begin
                        o_paddr <= base + APB_AW'(cnt_nx) * APB_AW'(STEP);
                        state   <= SETUP;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_rd_seq.sv
// tb_apb_rd_seq: directed scenarios for apb_rd_seq with cycle-scripted APB slave responses
module tb_apb_rd_seq;
    logic clk = 0, rst = 0, i_start = 0, i_pready = 0, i_pslverr = 0;
    logic [31:0] i_addr = '0;
    logic [2:0] i_beats = '0;
    logic [7:0] i_prdata = '0;
    logic o_busy, o_psel, o_penable, o_pwrite, o_done, o_err;
    logic [31:0] o_paddr;
    logic [3:0] o_load;
    logic [7:0] o_data;
    int vectors = 0, miscompares = 0;

    apb_rd_seq dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_addr(i_addr), .i_beats(i_beats),
        .o_busy(o_busy), .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
        .o_paddr(o_paddr), .i_pready(i_pready), .i_pslverr(i_pslverr), .i_prdata(i_prdata),
        .o_load(o_load), .o_data(o_data), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drives one burst; wb/nw put nw wait states on beat wb, eb is the PSLVERR beat (-1 = none)
    task automatic burst(input logic [31:0] addr, input logic [2:0] nbi, input int wb, input int nw,
                         input int eb, output int lat);
        int nb, last, w;
        logic [31:0] ea;
        logic [3:0] el;
        nb = (nbi == 0) ? 1 : int'(nbi);
        last = (eb >= 0 && eb < nb) ? eb : nb - 1;
        i_start = 1; i_addr = addr; i_beats = nbi;
        tick();
        i_start = 0;
        lat = 1;
        for (int b = 0; b <= last; b++) begin
            ea = addr + 32'(b);
            vectors++;
            if ({o_busy, o_psel, o_penable, o_pwrite} !== 4'b1100 || o_paddr !== ea || o_load !== 4'b0) begin
                miscompares++;
                $display("FAIL setup beat %0d: busy/psel/pen/pwr=%b paddr=%h load=%b want 1100 %h 0000",
                         b, {o_busy, o_psel, o_penable, o_pwrite}, o_paddr, o_load, ea);
            end
            tick(); lat++;
            w = (b == wb) ? nw : 0;
            for (int k = 0; k <= w; k++) begin
                i_pready = (k == w);
                i_pslverr = (k == w) && (b == eb);
                i_prdata = 8'(8'h11 * (b + 1));
                el = (k == w && b != eb) ? 4'(1 << b) : 4'b0;
                #1;
                vectors++;
                if ({o_psel, o_penable} !== 2'b11 || o_paddr !== ea || o_load !== el || o_data !== i_prdata) begin
                    miscompares++;
                    $display("FAIL access beat %0d cyc %0d: psel/pen=%b paddr=%h load=%b data=%h want 11 %h %b %h",
                             b, k, {o_psel, o_penable}, o_paddr, o_load, o_data, ea, el, i_prdata);
                end
                tick(); lat++;
                i_pready = 0; i_pslverr = 0;
            end
        end
        vectors++;
        if ({o_done, o_err, o_busy, o_psel, o_load} !== {1'b1, last == eb, 1'b1, 1'b0, 4'b0}) begin
            miscompares++;
            $display("FAIL done: done/err/busy/psel=%b load=%b want %b 0000",
                     {o_done, o_err, o_busy, o_psel}, o_load, {1'b1, last == eb, 2'b10});
        end
        tick();
        vectors++;
        if ({o_done, o_err, o_busy, o_psel, o_penable} !== 5'b0) begin
            miscompares++;
            $display("FAIL idle after done: done/err/busy/psel/pen=%b want 00000",
                     {o_done, o_err, o_busy, o_psel, o_penable});
        end
    endtask

    task automatic test_reset();
        i_prdata = 8'h5A;
        #1;
        vectors++;
        if ({o_busy, o_psel, o_penable, o_pwrite, o_done, o_err} !== 6'b0 || o_paddr !== 0 || o_load !== 0 || o_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL reset: flags=%b paddr=%h load=%b data=%h want 000000 0 0 5a",
                     {o_busy, o_psel, o_penable, o_pwrite, o_done, o_err}, o_paddr, o_load, o_data);
        end
        tick(); rst = 1; tick();
    endtask

    task automatic test_full_burst();
        int lat;
        burst(32'h100, 3'd4, -1, 0, -1, lat);
        vectors++;
        if (lat !== 9) begin miscompares++; $display("FAIL full burst latency: got %0d want 9", lat); end
    endtask

    task automatic test_wait_states();
        int lat;
        burst(32'h100, 3'd4, 1, 3, -1, lat);
        vectors++;
        if (lat !== 12) begin miscompares++; $display("FAIL wait latency: got %0d want 12", lat); end
    endtask

    task automatic test_slave_error();
        int lat;
        burst(32'h100, 3'd4, -1, 0, 2, lat);
        vectors++;
        if (lat !== 7 || o_paddr === 32'h103) begin
            miscompares++;
            $display("FAIL slverr: latency %0d paddr %h want 7 and paddr not 103", lat, o_paddr);
        end
    endtask

    task automatic test_single_and_zero();
        int lat;
        burst(32'h200, 3'd1, -1, 0, -1, lat);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL single beat latency: got %0d want 3", lat); end
        burst(32'h300, 3'd0, -1, 0, -1, lat);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL zero count latency: got %0d want 3", lat); end
    endtask

    task automatic test_wrap();
        int lat;
        burst(32'hFFFF_FFFE, 3'd4, -1, 0, -1, lat);
        vectors++;
        if (lat !== 9) begin miscompares++; $display("FAIL wrap latency: got %0d want 9", lat); end
    endtask

    task automatic test_reset_mid_burst();
        int lat;
        i_start = 1; i_addr = 32'h400; i_beats = 3'd4;
        tick(); i_start = 0;
        tick(); i_pready = 1;
        tick(); i_pready = 0;
        tick();
        vectors++;
        if ({o_psel, o_penable} !== 2'b11 || o_paddr !== 32'h401) begin
            miscompares++;
            $display("FAIL pre-reset access: psel/pen=%b paddr=%h want 11 401", {o_psel, o_penable}, o_paddr);
        end
        i_pready = 1;
        rst = 0;
        #1;
        vectors++;
        if ({o_busy, o_psel, o_penable, o_done, o_err} !== 5'b0 || o_paddr !== 0 || o_load !== 0) begin
            miscompares++;
            $display("FAIL async reset: flags=%b paddr=%h load=%b want 00000 0 0",
                     {o_busy, o_psel, o_penable, o_done, o_err}, o_paddr, o_load);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (o_done !== 1'b0 || o_load !== 0) begin
                miscompares++;
                $display("FAIL done during reset: done=%b load=%b want 0 0000", o_done, o_load);
            end
        end
        i_pready = 0;
        rst = 1;
        tick();
        burst(32'h500, 3'd2, -1, 0, -1, lat);
        vectors++;
        if (lat !== 5) begin miscompares++; $display("FAIL post-reset latency: got %0d want 5", lat); end
    endtask

    task automatic test_back_to_back();
        i_start = 1; i_addr = 32'h40; i_beats = 3'd1;
        tick();
        i_addr = 32'h80;
        tick();
        i_pready = 1; i_prdata = 8'hC3;
        #1;
        vectors++;
        if (o_paddr !== 32'h40 || o_load !== 4'b0001 || o_data !== 8'hC3) begin
            miscompares++;
            $display("FAIL b2b first access: paddr=%h load=%b data=%h want 40 0001 c3", o_paddr, o_load, o_data);
        end
        tick(); i_pready = 0;
        vectors++;
        if ({o_done, o_err, o_busy} !== 3'b101) begin
            miscompares++;
            $display("FAIL b2b first done: done/err/busy=%b want 101", {o_done, o_err, o_busy});
        end
        tick();
        vectors++;
        if ({o_busy, o_psel, o_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL b2b idle gap: busy/psel/done=%b want 000", {o_busy, o_psel, o_done});
        end
        tick(); i_start = 0;
        vectors++;
        if ({o_busy, o_psel, o_penable} !== 3'b110 || o_paddr !== 32'h80) begin
            miscompares++;
            $display("FAIL b2b second setup: busy/psel/pen=%b paddr=%h want 110 80",
                     {o_busy, o_psel, o_penable}, o_paddr);
        end
        tick(); i_pready = 1;
        tick(); i_pready = 0;
        vectors++;
        if ({o_done, o_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b second done: done/err=%b want 10", {o_done, o_err});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_wait_states();
        test_slave_error();
        test_single_and_zero();
        test_wrap();
        test_reset_mid_burst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apb_rd_seq.md
# apb_rd_seq

APB read sequencer for the AHB-to-APB bridge. It turns one AHB read request into 1 to NBEATS back-to-back APB read transfers. Each completed beat produces a one-hot load strobe and the beat's PRDATA, which feed the APB_DW-wide slice registers inside the HRDATA assembly stage directly downstream. When all beats are captured, or a slave error ends the burst early, it pulses a done flag back to the AHB-side control.

## Interface
- AHB_DW, 32, AHB data width; integer multiple of APB_DW.
- APB_DW, 8, APB data width; one of 8, 16 or 32.
- APB_AW, 32, APB address width.
- NBEATS, AHB_DW/APB_DW, derived localparam; never overridden.
- clk  in  1  bridge clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  request strobe; sampled only in IDLE.
- i_addr  in  APB_AW  byte address of beat 0.
- i_beats  in  $clog2(NBEATS)+1  beat count, 1..NBEATS.
- o_busy  out  1  high in every state except IDLE.
- o_psel, o_penable  out  1  APB select and enable.
- o_pwrite  out  1  tied 0.
- o_paddr  out  APB_AW  APB address.
- i_pready, i_pslverr  in  1  APB slave response.
- i_prdata  in  APB_DW  APB read data.
- o_load  out  NBEATS  one-hot slice load strobe; bit k loads slice k.
- o_data  out  APB_DW  data for the loaded slice.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_done; 1 means PSLVERR ended the burst.

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If i_start=1, latch i_addr and i_beats, clear the beat counter and the error flag, and go to SETUP.
  - If i_beats=0, treat it as 1.
- SETUP: o_psel=1, o_penable=0, o_paddr = latched base + cnt*(APB_DW/8). Always go to ACCESS next.
- ACCESS: o_psel=1, o_penable=1, o_paddr held.
  - i_pready=0: stay in ACCESS (wait state); all APB outputs held.
  - i_pready=1, i_pslverr=0: o_load[cnt]=1 this cycle, cnt increments. If cnt+1 == beats, go to DONE; otherwise go to SETUP.
  - i_pready=1, i_pslverr=1: no load strobe, set the error flag, go to DONE. Remaining beats are abandoned.
- DONE: o_done=1, o_err = error flag. Go to IDLE unconditionally.
- o_load and o_data are combinational, so the downstream register captures on the same edge that completes the APB transfer:
  - o_load = (state==ACCESS & i_pready & !i_pslverr) << cnt
  - o_data = i_prdata
- Address arithmetic is modulo 2^APB_AW; wrap-around is permitted and not flagged.
- The latched base is not aligned or modified by this block.
- i_start outside IDLE is ignored; the requester holds its request until o_done.
- Reset, including mid-burst, returns to IDLE with all outputs 0. Abandoned beats produce no o_done.

## Timing
- Reset values: o_busy, o_psel, o_penable, o_pwrite, o_paddr, o_load, o_done, o_err are all 0; o_data follows i_prdata.
- Zero-wait beat: 2 cycles, SETUP then ACCESS. Each wait state adds 1 cycle.
- Request-to-done latency with no waits: 2*beats + 1 cycles after the i_start edge. o_done is asserted in the cycle after the last ACCESS.
- o_psel stays high between consecutive beats; o_penable drops for exactly one SETUP cycle.
- A back-to-back request may assert i_start while o_done=1. It is first sampled in the following IDLE cycle, so there is a minimum 1 idle cycle between bursts.
- At most one bit of o_load is set per cycle, and only in a cycle where i_pready=1.

## Structure
- A shared package holds the state encoding (2-bit IDLE/SETUP/ACCESS/DONE) and the NBEATS/count-width computation, so the HRDATA assembly stage uses identical widths.
- Single module, no sub-modules. The beat counter and address adder are inline.

## Test plan
- Full burst, zero waits: AHB_DW=32, APB_DW=8, i_addr=0x100, i_beats=4, PRDATA 0x11, 0x22, 0x33, 0x44 -> paddr 0x100..0x103, o_load 0001, 0010, 0100, 1000 in the four ACCESS cycles, o_done at cycle 9 with o_err=0.
- Wait states: beat 1 holds i_pready=0 for 3 cycles -> psel, penable and paddr=0x101 stable throughout, no o_load during the waits, total latency 12 cycles.
- Slave error: PSLVERR=1 on beat 2 of 4 -> only o_load[0] and o_load[1] fire, o_done with o_err=1 one cycle later, paddr 0x103 never driven.
- Single beat and zero count: i_beats=1, and separately i_beats=0 -> exactly one transfer each, o_done after 3 cycles.
- Address wrap: APB_AW=8, i_addr=0xFE, i_beats=4 -> paddr FE, FF, 00, 01.
- Reset mid-burst: deassert rst during ACCESS of beat 2 -> all outputs 0 immediately, no o_done. A new request afterwards completes normally.
